bali_rr_arbiter: RTL and testbench

//   Round-robin arbiter that shares one PCIe application resource among NUM_REQ

---
 rtl/bali_rr_arbiter.sv | 93 +++++++++
 tb/tb_bali_rr_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/bali_rr_arbiter.sv
// bali_rr_arbiter: locked round-robin arbiter sharing one PCIe application resource
// Ports: clk, rst_n (async active-low), arb_en (allow new grants), req[NUM_REQ] (level requests),
//   done (owner release pulse), gnt (registered one-hot), gnt_vld, gnt_idx (binary of gnt, 0 when idle),
//   busy (grant held), timeout (forced-release pulse).
// Optional feature macro BALI_ARB_TIMEOUT_EN: bounds grant hold time to TIMEOUT_CYC cycles.
module bali_rr_arbiter #(
  parameter int NUM_REQ = 16,
  parameter int IDX_W = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arb_en,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_vld,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               busy,
  output logic               timeout
);
  if (!(NUM_REQ inside {4, 8, 16, 32}) || IDX_W != $clog2(NUM_REQ) || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("bali_rr_arbiter: illegal parameter combination");
  end
  typedef enum logic {IDLE, OWN} state_t;
  state_t state;
  logic [IDX_W-1:0] ptr, win;
  logic found, rel, expire;
  // NUM_REQ is a power of two, so IDX_W-bit addition wraps the scan back to 0
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (!found && req[ptr + IDX_W'(i)]) begin
        win = ptr + IDX_W'(i);
        found = 1'b1;
      end
  end
  assign rel = done | ~req[gnt_idx];
`ifdef BALI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0] timer;
  // a real release in the expiry cycle takes precedence, so timeout only flags forced releases
  assign expire = timer == TW'(TIMEOUT_CYC - 1) && !rel;
`else
  assign expire = 1'b0;
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      gnt <= '0;
      gnt_vld <= 1'b0;
      gnt_idx <= '0;
      busy <= 1'b0;
      ptr <= '0;
`ifdef BALI_ARB_TIMEOUT_EN
      timer <= '0;
      timeout <= 1'b0;
`endif
    end else begin
`ifdef BALI_ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      if (state == IDLE) begin
        if (arb_en && found) begin
          state <= OWN;
          gnt <= NUM_REQ'(1) << win;
          gnt_vld <= 1'b1;
          gnt_idx <= win;
          busy <= 1'b1;
`ifdef BALI_ARB_TIMEOUT_EN
          timer <= '0;
`endif
        end
      end else begin
`ifdef BALI_ARB_TIMEOUT_EN
        timer <= timer + TW'(1);
`endif
        if (rel || expire) begin
          state <= IDLE;
          gnt <= '0;
          gnt_vld <= 1'b0;
          gnt_idx <= '0;
          busy <= 1'b0;
          ptr <= gnt_idx + IDX_W'(1);
`ifdef BALI_ARB_TIMEOUT_EN
          timeout <= expire;
`endif
        end
      end
    end
endmodule

// File: tb/tb_bali_rr_arbiter.sv
// tb_bali_rr_arbiter: directed checks of bali_rr_arbiter with NUM_REQ=16, TIMEOUT_CYC=8
module tb_bali_rr_arbiter;
  logic clk = 1'b0, rst_n = 1'b0, arb_en = 1'b1, done = 1'b0;
  logic [15:0] req = 16'hFFFF;
  logic [15:0] gnt;
  logic gnt_vld, busy, timeout;
  logic [3:0] gnt_idx;
  int tests = 0, fails = 0;
  bali_rr_arbiter #(.NUM_REQ(16), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req(req), .done(done),
    .gnt(gnt), .gnt_vld(gnt_vld), .gnt_idx(gnt_idx), .busy(busy), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic own(input string tag, input int idx);
    chk({tag, " gnt"}, 32'(gnt), 32'h1 << idx);
    chk({tag, " idx"}, 32'(gnt_idx), 32'(idx));
    chk({tag, " vld"}, 32'(gnt_vld), 32'd1);
    chk({tag, " busy"}, 32'(busy), 32'd1);
  endtask
  task automatic idle(input string tag);
    chk({tag, " gnt"}, 32'(gnt), 32'h0);
    chk({tag, " idx"}, 32'(gnt_idx), 32'h0);
    chk({tag, " vld"}, 32'(gnt_vld), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
  endtask
  initial begin
    tick();
    tick();
    idle("reset");
    chk("reset timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;
    tick();
    own("first", 0);
    for (int i = 1; i <= 16; i++) begin
      done = 1'b1;
      tick();
      idle($sformatf("rr gap %0d", i));
      done = 1'b0;
      tick();
      own($sformatf("rr %0d", i), i % 16);
    end
    done = 1'b1;
    req = 16'h4000;
    tick();
    done = 1'b0;
    tick();
    own("to14", 14);
    req = 16'h8001;
    done = 1'b1;
    tick();
    idle("after14");
    done = 1'b0;
    tick();
    own("ptr15", 15);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    own("wrap", 0);
    req = 16'h0008;
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    own("own3", 3);
    req = 16'h0028;
    tick();
    own("frozen3", 3);
    req = 16'h0020;
    tick();
    idle("abort3");
    tick();
    own("after abort", 5);
    req = 16'h0004;
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    own("own2", 2);
    arb_en = 1'b0;
    tick();
    own("hold2 arb_en0", 2);
    req = 16'h00F4;
    done = 1'b1;
    tick();
    idle("rel2");
    done = 1'b0;
    req = 16'h00F0;
    tick();
    tick();
    idle("arb_en0 idle");
    arb_en = 1'b1;
    tick();
    own("arb_en1", 4);
    req = 16'h00E0;
    done = 1'b1;
    tick();
    idle("done+abort");
    done = 1'b0;
    tick();
    own("single release", 5);
    req = 16'h0080;
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    own("own7", 7);
    #3;
    req = 16'h0081;
    rst_n = 1'b0;
    #1;
    idle("async reset");
    tick();
    idle("held reset");
    rst_n = 1'b1;
    tick();
    own("post reset", 0);
    req = 16'h0001;
`ifdef BALI_ARB_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin
      tick();
      own($sformatf("pre-expiry %0d", i), 0);
      chk("no early timeout", 32'(timeout), 32'd0);
    end
    tick();
    idle("expired");
    chk("timeout pulse", 32'(timeout), 32'd1);
    tick();
    chk("timeout one cycle", 32'(timeout), 32'd0);
    own("regrant", 0);
`else
    for (int i = 0; i < 120; i++) begin
      tick();
      chk("no timeout", 32'(timeout), 32'd0);
      chk("held gnt", 32'(gnt), 32'h1);
    end
    own("held long", 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
